// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the pad configuration controller.
// Register map: pad words at 0..N_IO-1, LOCK at 62, STATUS at 63.
package pad_cfg_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        IDLE      = 2'd1,
        APPLY_OFF = 2'd2,
        APPLY_ON  = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_LOCK   = 6'd62;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 6'd63;

    localparam int CFG_LSB = 0;
    localparam int MUX_LSB = 8;

endpackage

// File: rtl/pad_cfg_ctrl_if.sv
// Register access port (req/gnt with one-cycle response) for pad_cfg_ctrl.
interface pad_cfg_ctrl_if;
    import pad_cfg_pkg::*;

    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/pad_cfg_regfile.sv
// Per-pad cfg and mux-select storage: independent cfg/mux write ports,
// combinational read of one pad, and flattened views toward the pad frame.
module pad_cfg_regfile #(
    parameter int N_IO        = 48,
    parameter int NBIT_PADCFG = 6,
    parameter int NBIT_MUX    = 2,
    parameter int IDX_W       = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_we,
    input  logic [IDX_W-1:0]            i_cfg_idx,
    input  logic [NBIT_PADCFG-1:0]      i_cfg_wdata,
    input  logic                        i_mux_we,
    input  logic [IDX_W-1:0]            i_mux_idx,
    input  logic [NBIT_MUX-1:0]         i_mux_wdata,
    input  logic [IDX_W-1:0]            i_rd_idx,
    output logic [NBIT_PADCFG-1:0]      o_rd_cfg,
    output logic [NBIT_MUX-1:0]         o_rd_mux,
    output logic [N_IO*NBIT_PADCFG-1:0] o_pad_cfg,
    output logic [N_IO*NBIT_MUX-1:0]    o_pad_mux
);

    logic [NBIT_PADCFG-1:0] r_cfg [N_IO];
    logic [NBIT_MUX-1:0]    r_mux [N_IO];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_IO; i++) begin
                r_cfg[i] <= '0;
                r_mux[i] <= '0;
            end
        end else begin
            if (i_cfg_we) begin
                r_cfg[i_cfg_idx] <= i_cfg_wdata;
            end
            if (i_mux_we) begin
                r_mux[i_mux_idx] <= i_mux_wdata;
            end
        end
    end

    // Callers only consume the read port for in-range indices.
    assign o_rd_cfg = r_cfg[i_rd_idx];
    assign o_rd_mux = r_mux[i_rd_idx];

    for (genvar g = 0; g < N_IO; g++) begin : g_flat
        assign o_pad_cfg[g*NBIT_PADCFG +: NBIT_PADCFG] = r_cfg[g];
        assign o_pad_mux[g*NBIT_MUX +: NBIT_MUX]       = r_mux[g];
    end

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad config/mux owner with staggered OE release after reset and
// break-before-make OE masking on mux changes. Optional: `PAD_CFG_LOCK_EN.
module pad_cfg_ctrl
    import pad_cfg_pkg::*;
#(
    parameter int N_IO        = 48,
    parameter int NBIT_PADCFG = 6,
    parameter int NBIT_MUX    = 2,
    parameter int STAGGER     = 4,
    parameter int GUARD       = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    pad_cfg_ctrl_if.slave               bus,
    output logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_o,
    output logic [N_IO*NBIT_MUX-1:0]    pad_mux_o,
    output logic [N_IO-1:0]             pad_oe_mask_o,
    output logic                        init_done_o
);

    localparam logic [1:0] ST_INIT      = INIT;
    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_APPLY_OFF = APPLY_OFF;
    localparam logic [1:0] ST_APPLY_ON  = APPLY_ON;

    localparam int SCNT_W = $clog2(STAGGER + 1);
    localparam int GCNT_W = $clog2(GUARD + 1);
    localparam logic [ADDR_W:0] N_IO_L = (ADDR_W+1)'(N_IO);

    logic [1:0]            r_state;
    logic [ADDR_W-1:0]     r_idx;
    logic [SCNT_W-1:0]     r_scnt;
    logic [GCNT_W-1:0]     r_gcnt;
    logic [N_IO-1:0]       r_mask;
    logic                  r_init_done;
    logic [ADDR_W-1:0]     r_k;
    logic [NBIT_MUX-1:0]   r_new_mux;
    logic [ADDR_W-1:0]     r_last_k;
    logic                  r_rvalid;
    logic                  r_err;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_gnt;
    logic                  w_pad_addr;
    logic                  w_lock;
    logic                  w_cfg_we;
    logic                  w_mux_chg;
    logic                  w_mux_we;
    logic                  w_err;
    logic [DATA_W-1:0]     w_rdata;
    logic [NBIT_MUX-1:0]   w_mux_new;
    logic [NBIT_MUX-1:0]   w_rd_mux;
    logic [NBIT_PADCFG-1:0] w_rd_cfg;
    logic                  w_unused;

    assign w_gnt      = bus.req_i && (r_state == ST_IDLE) && !rst_i;
    assign w_pad_addr = ({1'b0, bus.addr_i} < N_IO_L);
    assign w_mux_new  = bus.wdata_i[MUX_LSB +: NBIT_MUX];
    assign w_cfg_we   = w_gnt && bus.we_i && w_pad_addr && !w_lock;
    assign w_mux_chg  = w_cfg_we && (w_mux_new != w_rd_mux);
    assign w_mux_we   = (r_state == ST_APPLY_OFF) && (r_gcnt == GCNT_W'(GUARD - 1));
    assign w_unused   = ^bus.wdata_i;

`ifdef PAD_CFG_LOCK_EN
    logic r_lock;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock <= 1'b0;
        end else if (w_gnt && bus.we_i && (bus.addr_i == ADDR_LOCK) && bus.wdata_i[0]) begin
            r_lock <= 1'b1;
        end
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Response decode: writes return zero data; error on anything unmapped.
    always_comb begin
        w_err   = 1'b1;
        w_rdata = '0;
        if (w_pad_addr) begin
            if (bus.we_i) begin
                w_err = w_lock;
            end else begin
                w_err = 1'b0;
                w_rdata[MUX_LSB +: NBIT_MUX]    = w_rd_mux;
                w_rdata[CFG_LSB +: NBIT_PADCFG] = w_rd_cfg;
            end
        end else if (bus.addr_i == ADDR_STATUS) begin
            if (!bus.we_i) begin
                w_err       = 1'b0;
                w_rdata[0]  = r_init_done;
                w_rdata[1]  = w_lock;
                w_rdata[13:8] = r_last_k;
            end
        end
`ifdef PAD_CFG_LOCK_EN
        else if (bus.addr_i == ADDR_LOCK) begin
            w_err = 1'b0;
            if (!bus.we_i) begin
                w_rdata[0] = w_lock;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_INIT;
            r_idx       <= '0;
            r_scnt      <= '0;
            r_gcnt      <= '0;
            r_mask      <= '0;
            r_init_done <= 1'b0;
            r_k         <= '0;
            r_new_mux   <= '0;
            r_last_k    <= '0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt && w_err;
            r_rdata  <= w_gnt ? w_rdata : '0;
            case (r_state)
                ST_INIT: begin
                    if (r_scnt == SCNT_W'(STAGGER - 1)) begin
                        r_scnt        <= '0;
                        r_mask[r_idx] <= 1'b1;
                        if (r_idx == ADDR_W'(N_IO - 1)) begin
                            r_state     <= ST_IDLE;
                            r_init_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_scnt <= r_scnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Break before make: drop the pad's OE before the mux moves.
                    if (w_mux_chg) begin
                        r_k                 <= bus.addr_i;
                        r_new_mux           <= w_mux_new;
                        r_mask[bus.addr_i]  <= 1'b0;
                        r_gcnt              <= '0;
                        r_state             <= ST_APPLY_OFF;
                    end
                end
                ST_APPLY_OFF: begin
                    if (w_mux_we) begin
                        r_state <= ST_APPLY_ON;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                ST_APPLY_ON: begin
                    r_mask[r_k] <= 1'b1;
                    r_last_k    <= r_k;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    pad_cfg_regfile #(
        .N_IO        (N_IO),
        .NBIT_PADCFG (NBIT_PADCFG),
        .NBIT_MUX    (NBIT_MUX),
        .IDX_W       (ADDR_W)
    ) u_regfile (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_cfg_we    (w_cfg_we),
        .i_cfg_idx   (bus.addr_i),
        .i_cfg_wdata (bus.wdata_i[CFG_LSB +: NBIT_PADCFG]),
        .i_mux_we    (w_mux_we),
        .i_mux_idx   (r_k),
        .i_mux_wdata (r_new_mux),
        .i_rd_idx    (bus.addr_i),
        .o_rd_cfg    (w_rd_cfg),
        .o_rd_mux    (w_rd_mux),
        .o_pad_cfg   (pad_cfg_o),
        .o_pad_mux   (pad_mux_o)
    );

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_rvalid;
    assign bus.err_o    = r_err;
    assign bus.rdata_o  = r_rdata;
    assign pad_oe_mask_o = r_mask;
    assign init_done_o   = r_init_done;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl: staggered init, mux apply, errors, reset abort, lock.
module tb_pad_cfg_ctrl;
    import pad_cfg_pkg::*;

    localparam int N_IO        = 48;
    localparam int NBIT_PADCFG = 6;
    localparam int NBIT_MUX    = 2;
    localparam int STAGGER     = 4;
    localparam int GUARD       = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_IO*NBIT_PADCFG-1:0] pad_cfg;
    logic [N_IO*NBIT_MUX-1:0]    pad_mux;
    logic [N_IO-1:0]             pad_mask;
    logic                        init_done;

    pad_cfg_ctrl_if bus ();

    pad_cfg_ctrl #(
        .N_IO        (N_IO),
        .NBIT_PADCFG (NBIT_PADCFG),
        .NBIT_MUX    (NBIT_MUX),
        .STAGGER     (STAGGER),
        .GUARD       (GUARD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .pad_cfg_o     (pad_cfg),
        .pad_mux_o     (pad_mux),
        .pad_oe_mask_o (pad_mask),
        .init_done_o   (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [N_IO-1:0] ALL_ONES = '1;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NBIT_PADCFG-1:0] cfg_of(input int i);
        return pad_cfg[i*NBIT_PADCFG +: NBIT_PADCFG];
    endfunction

    function automatic logic [NBIT_MUX-1:0] mux_of(input int i);
        return pad_mux[i*NBIT_MUX +: NBIT_MUX];
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cfg"},   pad_cfg, '0);
        check({tag, "_mux"},   pad_mux, '0);
        check({tag, "_mask"},  pad_mask, '0);
        check({tag, "_done"},  init_done, 0);
        check({tag, "_rvalid"}, bus.rvalid_o, 0);
        check({tag, "_err"},   bus.err_o, 0);
        check({tag, "_rdata"}, bus.rdata_o, 0);
    endtask

    // Called at a negedge; returns at the negedge where the response is visible.
    task automatic access(input logic w, input logic [5:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a; bus.wdata_i = d;
        #1;
        while (!bus.gnt_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.gnt_o) begin
            check("gnt_timeout", 0, 1);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        check("acc_rvalid", bus.rvalid_o, 1);
        rd = bus.rdata_o;
        er = bus.err_o;
    endtask

    task automatic run_table(input vec_t vt[], input string tag);
        logic [31:0] rd;
        logic        er;
        foreach (vt[i]) begin
            access(vt[i].we, vt[i].addr, vt[i].wdata, rd, er);
            check($sformatf("%s%0d_rdata", tag, i), rd, vt[i].exp_rdata);
            check($sformatf("%s%0d_err", tag, i), er, vt[i].exp_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[];
        vec_t lt[];
        logic [31:0] rd;
        logic        er;
        logic [N_IO*NBIT_PADCFG-1:0] exp_cfg;
        logic [N_IO*NBIT_MUX-1:0]    exp_mux;

        vt = new[13];
        vt[0]  = '{1'b0, 6'd5,  32'h0,         32'h10C, 1'b0};
        vt[1]  = '{1'b1, 6'd50, 32'hFF,        32'h0,   1'b1};
        vt[2]  = '{1'b1, 6'd63, 32'h1,         32'h0,   1'b1};
        vt[3]  = '{1'b0, 6'd61, 32'h0,         32'h0,   1'b1};
        vt[4]  = '{1'b0, 6'd48, 32'h0,         32'h0,   1'b1};
        vt[5]  = '{1'b0, 6'd47, 32'h0,         32'h0,   1'b0};
        vt[6]  = '{1'b0, 6'd63, 32'h0,         32'h501, 1'b0};
        vt[7]  = '{1'b1, 6'd7,  32'hFFFF_F2AA, 32'h0,   1'b0};
        vt[8]  = '{1'b0, 6'd7,  32'h0,         32'h22A, 1'b0};
        vt[9]  = '{1'b0, 6'd63, 32'h0,         32'h701, 1'b0};
        vt[10] = '{1'b0, 6'd0,  32'h0,         32'h0,   1'b0};
        vt[11] = '{1'b1, 6'd0,  32'h3F,        32'h0,   1'b0};
        vt[12] = '{1'b0, 6'd0,  32'h0,         32'h3F,  1'b0};

        lt = new[5];
`ifdef PAD_CFG_LOCK_EN
        lt[0] = '{1'b1, 6'd62, 32'h1,  32'h0, 1'b0};
        lt[1] = '{1'b1, 6'd2,  32'h33, 32'h0, 1'b1};
        lt[2] = '{1'b0, 6'd2,  32'h0,  32'h0, 1'b0};
        lt[3] = '{1'b0, 6'd62, 32'h0,  32'h1, 1'b0};
        lt[4] = '{1'b0, 6'd63, 32'h0,  32'h3, 1'b0};
`else
        lt[0] = '{1'b1, 6'd62, 32'h1,  32'h0,  1'b1};
        lt[1] = '{1'b0, 6'd62, 32'h0,  32'h0,  1'b1};
        lt[2] = '{1'b0, 6'd63, 32'h0,  32'h1,  1'b0};
        lt[3] = '{1'b1, 6'd2,  32'h33, 32'h0,  1'b0};
        lt[4] = '{1'b0, 6'd2,  32'h0,  32'h33, 1'b0};
`endif

        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;

        // Reset and staggered release
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst");
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 6'd0;
        #1;
        check("init_gnt", bus.gnt_o, 0);
        wait_edges(3);
        check("init_mask_c3", pad_mask, '0);
        wait_edges(1);
        check("init_mask_c4", pad_mask, 1);
        check("init_norvalid", bus.rvalid_o, 0);
        wait_edges(N_IO*STAGGER - 5);
        check("init_gnt_late", bus.gnt_o, 0);
        check("init_mask_c191", pad_mask[N_IO-1], 0);
        check("init_done_c191", init_done, 0);
        bus.req_i = 1'b0;
        wait_edges(1);
        check("init_mask_c192", pad_mask, ALL_ONES);
        check("init_done_c192", init_done, 1);

        // Mux change on pad 5: OE masked GUARD+1 cycles
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 6'd5; bus.wdata_i = 32'h0000_0115;
        #1;
        check("apply_gnt", bus.gnt_o, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        check("apply_rvalid", bus.rvalid_o, 1);
        check("apply_err", bus.err_o, 0);
        check("apply_cfg5", cfg_of(5), 6'h15);
        check("apply_mask5_a", pad_mask[5], 0);
        check("apply_mux5_a", mux_of(5), 0);
        wait_edges(1);
        check("apply_rvalid_1cyc", bus.rvalid_o, 0);
        check("apply_mask5_b", pad_mask[5], 0);
        check("apply_mux5_b", mux_of(5), 0);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 6'd5;
        #1;
        check("apply_busy_gnt", bus.gnt_o, 0);
        bus.req_i = 1'b0;
        wait_edges(1);
        check("apply_mask5_c", pad_mask[5], 0);
        check("apply_mux5_c", mux_of(5), 1);
        wait_edges(1);
        check("apply_mask_done", pad_mask, ALL_ONES);
        access(1'b0, 6'd5, 32'h0, rd, er);
        check("apply_read5", rd, 32'h115);
        check("apply_read5_err", er, 0);

        // Same mux, back-to-back writes: no OE drop, gnt every cycle
        for (int i = 0; i < 3; i++) begin
            logic [5:0] c;
            c = (i == 0) ? 6'h03 : (i == 1) ? 6'h07 : 6'h0C;
            bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 6'd5; bus.wdata_i = {22'h0, 2'b01, 2'b00, c};
            #1;
            check($sformatf("b2b%0d_gnt", i), bus.gnt_o, 1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b%0d_rvalid", i), bus.rvalid_o, 1);
            check($sformatf("b2b%0d_cfg5", i), cfg_of(5), c);
            check($sformatf("b2b%0d_mask", i), pad_mask, ALL_ONES);
        end
        bus.req_i = 1'b0;
        wait_edges(1);
        check("b2b_rvalid_end", bus.rvalid_o, 0);

        run_table(vt, "vec");

        exp_cfg = '0;
        exp_mux = '0;
        exp_cfg[5*NBIT_PADCFG +: NBIT_PADCFG] = 6'h0C;
        exp_cfg[7*NBIT_PADCFG +: NBIT_PADCFG] = 6'h2A;
        exp_cfg[0 +: NBIT_PADCFG]             = 6'h3F;
        exp_mux[5*NBIT_MUX +: NBIT_MUX]       = 2'd1;
        exp_mux[7*NBIT_MUX +: NBIT_MUX]       = 2'd2;
        check("vec_pad_cfg", pad_cfg, exp_cfg);
        check("vec_pad_mux", pad_mux, exp_mux);
        check("vec_pad_mask", pad_mask, ALL_ONES);

        // Reset during APPLY_OFF aborts and restarts INIT
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 6'd9; bus.wdata_i = 32'h0000_0300;
        #1;
        check("abort_gnt", bus.gnt_o, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        check("abort_mask9", pad_mask[9], 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        wait_edges(4);
        check("abort_mask_c4", pad_mask, 1);
        wait_edges(35);
        check("abort_mask_c39", pad_mask, 48'h1FF);
        wait_edges(1);
        check("abort_mask_c40", pad_mask, 48'h3FF);
        wait_edges(N_IO*STAGGER - 40);
        check("abort_mask_done", pad_mask, ALL_ONES);
        check("abort_init_done", init_done, 1);
        check("abort_mux9", mux_of(9), 0);

        run_table(lt, "lock");
`ifdef PAD_CFG_LOCK_EN
        check("lock_cfg2", cfg_of(2), 0);
`else
        check("lock_cfg2", cfg_of(2), 6'h33);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
